// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit, 8-register RISC pipeline:
// opcodes, instruction field positions and small decode helpers.
package risc_pkg;

  localparam int NUM_REGS = 8;

  localparam logic [3:0] OP_ADI  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LLI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BLT  = 4'b1001;
  localparam logic [3:0] OP_BLE  = 4'b1010;
  localparam logic [3:0] OP_JAL  = 4'b1100;
  localparam logic [3:0] OP_JLR  = 4'b1101;
  localparam logic [3:0] OP_JRI  = 4'b1111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 9;
  localparam int RB_MSB  = 8;
  localparam int RB_LSB  = 6;
  localparam int RC_MSB  = 5;
  localparam int RC_LSB  = 3;
  localparam int SUB_MSB = 2;
  localparam int SUB_LSB = 0;

  function automatic logic [NUM_REGS-1:0] onehot3to8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: instruction word to register
// addresses, write mask and ALU/NAND sub-op controls.
module decode_comb
  import risc_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic [2:0]  add1,
  output logic [2:0]  add2,
  output logic [2:0]  wadd,
  output logic [7:0]  wen,
  output logic [2:0]  alu_ctrl,
  output logic [2:0]  nand_ctrl
);

  logic [3:0] opcode;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] rc;
  logic [2:0] sub;

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign ra     = instr[RA_MSB:RA_LSB];
  assign rb     = instr[RB_MSB:RB_LSB];
  assign rc     = instr[RC_MSB:RC_LSB];
  assign sub    = instr[SUB_MSB:SUB_LSB];

  // Bubbles and unassigned opcodes fall through with every field at zero.
  always_comb begin
    add1      = 3'd0;
    add2      = 3'd0;
    wadd      = 3'd0;
    wen       = 8'd0;
    alu_ctrl  = 3'd0;
    nand_ctrl = 3'd0;
    if (instr_valid) begin
      case (opcode)
        OP_ADI: begin
          add1 = ra;
          wadd = rb;
          wen  = onehot3to8(rb);
        end
        OP_ADD: begin
          add1     = ra;
          add2     = rb;
          wadd     = rc;
          wen      = onehot3to8(rc);
          alu_ctrl = sub;
        end
        OP_NAND: begin
          add1      = ra;
          add2      = rb;
          wadd      = rc;
          wen       = onehot3to8(rc);
          nand_ctrl = sub;
        end
        OP_LLI, OP_JAL: begin
          wadd = ra;
          wen  = onehot3to8(ra);
        end
        OP_LW, OP_JLR: begin
          add1 = rb;
          wadd = ra;
          wen  = onehot3to8(ra);
        end
        OP_SW, OP_BEQ, OP_BLT, OP_BLE: begin
          add1 = ra;
          add2 = rb;
        end
        // LM mask is bit-reversed: instr[7] selects R0, instr[0] selects R7.
        OP_LM: begin
          add1 = ra;
          wen  = {instr[0], instr[1], instr[2], instr[3],
                  instr[4], instr[5], instr[6], instr[7]};
        end
        OP_SM, OP_JRI: begin
          add1 = ra;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decoder.sv
// ID stage: combinational decode followed by the control half of the
// ID pipeline register. Reset clears outputs immediately, like a bubble.
module decoder
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        out_valid,
  output logic [2:0]  reg_add1,
  output logic [2:0]  reg_add2,
  output logic [2:0]  reg_write_add,
  output logic [7:0]  reg_write_en,
  output logic [2:0]  alu_ctrl,
  output logic [2:0]  nand_ctrl
);

  logic [2:0] add1_d, add2_d, wadd_d, alu_d, nand_d;
  logic [7:0] wen_d;
  logic       valid_q;
  logic [2:0] add1_q, add2_q, wadd_q, alu_q, nand_q;
  logic [7:0] wen_q;

  decode_comb u_decode_comb (
    .instr       (instr),
    .instr_valid (instr_valid),
    .add1        (add1_d),
    .add2        (add2_d),
    .wadd        (wadd_d),
    .wen         (wen_d),
    .alu_ctrl    (alu_d),
    .nand_ctrl   (nand_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      add1_q  <= 3'd0;
      add2_q  <= 3'd0;
      wadd_q  <= 3'd0;
      wen_q   <= 8'd0;
      alu_q   <= 3'd0;
      nand_q  <= 3'd0;
    end else begin
      valid_q <= instr_valid;
      add1_q  <= add1_d;
      add2_q  <= add2_d;
      wadd_q  <= wadd_d;
      wen_q   <= wen_d;
      alu_q   <= alu_d;
      nand_q  <= nand_d;
    end
  end

  assign out_valid     = valid_q;
  assign reg_add1      = add1_q;
  assign reg_add2      = add2_q;
  assign reg_write_add = wadd_q;
  assign reg_write_en  = wen_q;
  assign alu_ctrl      = alu_q;
  assign nand_ctrl     = nand_q;

endmodule

// File: tb/tb_decoder.sv
// Testbench for decoder: directed vectors plus randomized instructions
// compared against a table-driven reference model.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        out_valid;
  logic [2:0]  reg_add1, reg_add2, reg_write_add, alu_ctrl, nand_ctrl;
  logic [7:0]  reg_write_en;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    int add1;
    int add2;
    int wadd;
    int wen;
    int alu;
    int nandc;
    int valid;
  } expect_t;

  // Operand source per opcode: 0 none, 1 RA, 2 RB, 3 RC.
  int add1Src[16] = '{1, 1, 1, 0, 2, 1, 1, 1, 1, 1, 1, 0, 0, 2, 0, 1};
  int add2Src[16] = '{0, 2, 2, 0, 0, 2, 0, 0, 2, 2, 2, 0, 0, 0, 0, 0};
  int wSrc[16]    = '{2, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  decoder dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .out_valid     (out_valid),
    .reg_add1      (reg_add1),
    .reg_add2      (reg_add2),
    .reg_write_add (reg_write_add),
    .reg_write_en  (reg_write_en),
    .alu_ctrl      (alu_ctrl),
    .nand_ctrl     (nand_ctrl)
  );

  always #5 clk = ~clk;

  function automatic int field(input logic [15:0] w, input int sel);
    if (sel == 0) return 0;
    return int'((w >> (12 - 3 * sel)) & 16'h0007);
  endfunction

  function automatic expect_t model(input logic [15:0] w, input logic v);
    expect_t e = '{default: 0};
    int op = int'(w[15:12]);
    e.valid = int'(v);
    if (!v) return e;
    e.add1 = field(w, add1Src[op]);
    e.add2 = field(w, add2Src[op]);
    e.wadd = field(w, wSrc[op]);
    if (wSrc[op] != 0) e.wen = 1 << e.wadd;
    if (op == 6)
      for (int r = 0; r < 8; r++) e.wen |= int'((w >> (7 - r)) & 16'h1) << r;
    if (op == 1) e.alu = int'(w[2:0]);
    if (op == 2) e.nandc = int'(w[2:0]);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input expect_t e);
    checkOutput({name, ".valid"}, int'(out_valid), e.valid);
    checkOutput({name, ".add1"}, int'(reg_add1), e.add1);
    checkOutput({name, ".add2"}, int'(reg_add2), e.add2);
    checkOutput({name, ".wadd"}, int'(reg_write_add), e.wadd);
    checkOutput({name, ".wen"}, int'(reg_write_en), e.wen);
    checkOutput({name, ".alu"}, int'(alu_ctrl), e.alu);
    checkOutput({name, ".nand"}, int'(nand_ctrl), e.nandc);
  endtask

  task automatic applyStimulus(input logic [15:0] w, input logic v);
    expect_t e;
    @(negedge clk);
    instr       = w;
    instr_valid = v;
    e = model(w, v);
    @(posedge clk);
    #1;
    checkAll($sformatf("i%04h_v%0d", w, v), e);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    expect_t zero;
    logic [15:0] w;
    zero = model(16'h0000, 1'b0);

    rst = 1'b1;
    instr = 16'h1298;
    instr_valid = 1'b1;
    #2;
    checkAll("resetAsync", zero);
    repeat (2) @(posedge clk);
    #1;
    checkAll("resetHeld", zero);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h1298, 1'b1);
    applyStimulus(16'h4A84, 1'b1);
    applyStimulus(16'h6080, 1'b1);
    applyStimulus(16'h6081, 1'b1);
    applyStimulus(16'h8283, 1'b1);
    applyStimulus(16'h272C, 1'b1);
    applyStimulus(16'h1298, 1'b0);
    applyStimulus(16'hE298, 1'b1);
    applyStimulus(16'hBFFF, 1'b1);

    // Asynchronous reset between edges discards the in-flight decode.
    applyStimulus(16'h1298, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkAll("rstMidStream", zero);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h4A84, 1'b1);

    for (int op = 0; op < 16; op++) begin
      w = 16'($urandom);
      w[15:12] = 4'(op);
      applyStimulus(w, 1'b1);
    end

    for (int n = 0; n < 300; n++) begin
      applyStimulus(16'($urandom), ($urandom_range(0, 9) < 8));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/decoder.md
# decoder

Instruction decode stage for the 16-bit, 8-register, six-stage RISC pipeline. Takes the fetched instruction word from the IF/ID latch. Produces source register addresses, destination register address, a per-register write-enable mask and the ALU/NAND sub-op controls. Results are registered, so the block also acts as the control half of the ID-stage pipeline register.

## Interface
- No parameters. Data width is 16 bits, register-file depth is 8.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  16  instruction word
  - opcode = instr[15:12]
  - RA = instr[11:9]
  - RB = instr[8:6]
  - RC = instr[5:3]
- instr_valid  in  1  instr holds a real instruction. Low means a bubble or flush.
- out_valid  out  1  registered copy of instr_valid
- reg_add1  out  3  first source register
- reg_add2  out  3  second source register
- reg_write_add  out  3  destination register
- reg_write_en  out  8  write mask; bit r enables a write to register Rr
- alu_ctrl  out  3  ADD-family sub-op
- nand_ctrl  out  3  NAND-family sub-op

## Operation
Defaults for every field: 0. Bubbles (instr_valid=0) and unknown opcodes (1011, 1110) decode to all-zero fields.

Per-opcode field mapping:
- 0000 ADI (RB = RA + imm6)
  - add1 = RA
  - wadd = RB
  - wen = onehot(RB)
- 0001 ADD family (RC = RA op RB)
  - add1 = RA, add2 = RB
  - wadd = RC, wen = onehot(RC)
  - alu_ctrl = instr[2:0]
- 0010 NAND family
  - add1 = RA, add2 = RB
  - wadd = RC, wen = onehot(RC)
  - nand_ctrl = instr[2:0]
- 0011 LLI
  - wadd = RA, wen = onehot(RA)
- 0100 LW (RA = mem[RB + imm6])
  - add1 = RB
  - wadd = RA, wen = onehot(RA)
- 0101 SW (mem[RB + imm6] = RA)
  - add1 = RA, add2 = RB
  - no write
- 0110 LM
  - add1 = RA
  - wen[r] = instr[7-r] for r = 0..7, so instr[7] selects R0 and instr[0] selects R7
  - wadd = 0
- 0111 SM
  - add1 = RA
  - no write
- 1000 BEQ, 1001 BLT, 1010 BLE
  - add1 = RA, add2 = RB
  - no write
- 1100 JAL
  - wadd = RA, wen = onehot(RA)
- 1101 JLR
  - add1 = RB
  - wadd = RA, wen = onehot(RA)
- 1111 JRI
  - add1 = RA
  - no write

Additional rules:
- alu_ctrl is 0 unless the opcode is 0001.
- nand_ctrl is 0 unless the opcode is 0010.
- reg_write_en is exactly one-hot or zero for every opcode except LM.
- The decoder does not interpret condition flags; it only passes alu_ctrl and nand_ctrl through.

## Timing
- Decode logic is combinational from instr and instr_valid.
- All outputs are registered: 1-cycle latency from the instr sample at rising edge N to the outputs after edge N.
- The decoder holds no other state.
- rst asserted: all outputs go to 0 immediately, without waiting for a clock edge. Zero outputs are equivalent to a bubble.
- Reset mid-stream: the in-flight decode is discarded. The first instruction captured after rst deasserts decodes normally.
- Each edge overwrites the outputs. There is no stall input; the upstream latch holds instr to repeat a decode.

## Structure
- Shared package `risc_pkg`:
  - opcode localparams (OP_ADI … OP_JRI)
  - instruction field bit ranges
  - register-count constant 8
- One natural sub-module: `decode_comb`.
  - Purely combinational, instr to fields.
  - Wrapped by the register stage in decoder.
- An `onehot3to8` function belongs in the package.

## Test plan
- ADD R1,R2→R3 (0x1298, valid=1) → one cycle later: add1=1, add2=2, wadd=3, wen=0x08, alu_ctrl=000, nand_ctrl=000, out_valid=1.
- LW 0x4A84 → add1=2, add2=0, wadd=5, wen=0x20.
- LM 0x6080 → add1=0, wen=0x01; LM 0x6081 → wen=0x81.
- BEQ 0x8283 → add1=1, add2=2, wen=0x00.
- NAND 0x272C → add1=3, add2=4, wadd=5, wen=0x20, nand_ctrl=100, alu_ctrl=000.
- Reset and bubble handling:
  - Load 0x1298, then assert rst between edges → outputs 0 immediately.
  - valid=0 with instr=0x1298 → all outputs 0.
  - Opcode 1110 → all outputs 0.
